// File: rtl/nn_pio_responder.sv
// PIO handshake responder: executes CLEAR/MAC/READ/STATUS command words on one
// signed multiply-accumulate neuron and returns a 32-bit result under req/ack.
module nn_pio_responder #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        to_hw_sig,
    input  logic [31:0] to_sig_hw_port,
    output logic        to_sw_sig,
    output logic [31:0] to_isig_sw_port
);

    typedef enum logic [2:0] {IDLE, DECODE, MUL, ACC, ACK} state_t;

    localparam logic [1:0] OP_CLEAR  = 2'b00;
    localparam logic [1:0] OP_MAC    = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_STATUS = 2'b11;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t state, state_nxt;

    // Only the fields that some opcode uses are kept; relu shares bit 0 with x.
    logic [1:0]               op;
    logic signed [7:0]        w;
    logic [7:0]               x;
    logic signed [16:0]       prod;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         cnt;
    logic                     sat;

    logic                     load_resp;
    logic                     do_clear;
    logic                     do_acc;
    logic [31:0]              resp_nxt;
    logic signed [ACC_W:0]    sum;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic                     ovf;
    logic [CNT_W-1:0]         cnt_inc;
    logic signed [16:0]       prod_nxt;
    logic [31:0]              acc_ext;

    logic unused_bits;
    assign unused_bits = ^to_sig_hw_port[29:16];

    assign prod_nxt = w * $signed({1'b0, x});
    assign sum      = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
    // Overflow shows up as disagreement between the two top bits of the wide sum.
    assign ovf      = sum[ACC_W] != sum[ACC_W-1];
    assign acc_nxt  = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    assign acc_ext  = 32'(acc);

    always_comb begin
        state_nxt = state;
        load_resp = 1'b0;
        do_clear  = 1'b0;
        do_acc    = 1'b0;
        resp_nxt  = 32'h0;
        case (state)
            IDLE: if (to_hw_sig) state_nxt = DECODE;
            DECODE: begin
                if (op == OP_MAC) begin
                    state_nxt = MUL;
                end else begin
                    state_nxt = ACK;
                    load_resp = 1'b1;
                    case (op)
                        OP_CLEAR:  do_clear = 1'b1;
                        OP_READ:   resp_nxt = (x[0] && acc[ACC_W-1]) ? 32'h0 : acc_ext;
                        OP_STATUS: resp_nxt = {16'h4E4E, sat, 15'(cnt)};
                        default:   resp_nxt = 32'h0;
                    endcase
                end
            end
            MUL: state_nxt = ACC;
            ACC: begin
                state_nxt = ACK;
                do_acc    = 1'b1;
                load_resp = 1'b1;
                resp_nxt  = 32'(cnt_inc);
            end
            ACK: if (!to_hw_sig) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state           <= IDLE;
            op              <= OP_CLEAR;
            w               <= '0;
            x               <= '0;
            prod            <= '0;
            acc             <= '0;
            cnt             <= '0;
            sat             <= 1'b0;
            to_sw_sig       <= 1'b0;
            to_isig_sw_port <= 32'h0;
        end else begin
            state <= state_nxt;
            // The data word is sampled only on the IDLE-exit edge.
            if (state == IDLE && to_hw_sig) begin
                op <= to_sig_hw_port[31:30];
                w  <= to_sig_hw_port[15:8];
                x  <= to_sig_hw_port[7:0];
            end
            if (state == MUL) prod <= prod_nxt;
            if (do_clear) begin
                acc <= '0;
                cnt <= '0;
                sat <= 1'b0;
            end
            if (do_acc) begin
                acc <= acc_nxt;
                cnt <= cnt_inc;
                if (ovf) sat <= 1'b1;
            end
            if (load_resp) to_isig_sw_port <= resp_nxt;
            if (load_resp)
                to_sw_sig <= 1'b1;
            else if (state == ACK && !to_hw_sig)
                to_sw_sig <= 1'b0;
        end
    end

endmodule
